data_stack: RTL and testbench

Hardware LIFO for the 8-bit CPU datapath. It services the control unit's `stack_w_en` / `stack_r_en` strobes for push/pop and call/return. Push data comes from the register file or the PC. The top-of-stack is always presented on `pop_data` so the register-writeback mux or the program counter can consume it in the same cycle the pop is issued. Depth is tracked, and sticky overflow/underflow flags are provided for debug.

---
 rtl/data_stack.sv | 130 +++++++++++++
 tb/tb_data_stack.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/data_stack.sv
// Hardware LIFO for the CPU datapath: registered top-of-stack, depth tracking,
// and sticky overflow/underflow flags.
module data_stack #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clear,
  input  logic                       stack_w_en,
  input  logic                       stack_r_en,
  input  logic [WIDTH-1:0]           push_data,
  output logic [WIDTH-1:0]           pop_data,
  output logic [$clog2(DEPTH+1)-1:0] depth,
  output logic                       empty,
  output logic                       full,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int DW = $clog2(DEPTH + 1);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];

  logic [DW-1:0]    sp_q, sp_d;
  logic [WIDTH-1:0] top_q, top_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;

  logic             mem_we;
  logic [AW-1:0]    mem_waddr;
  logic [AW-1:0]    idx_top;
  logic [AW-1:0]    idx_below;
  logic             is_empty;
  logic             is_full;

  // Modular AW-bit arithmetic lands on the right slot even when sp == DEPTH
  // wraps the low bits to zero for a power-of-two depth.
  assign idx_top   = sp_q[AW-1:0] - AW'(1);
  assign idx_below = sp_q[AW-1:0] - AW'(2);
  assign is_empty  = (sp_q == '0);
  assign is_full   = (sp_q == DW'(DEPTH));

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    sp_d      = sp_q;
    top_d     = top_q;
    ovf_d     = ovf_q;
    unf_d     = unf_q;
    mem_we    = 1'b0;
    mem_waddr = sp_q[AW-1:0];

    if (clear) begin
      sp_d  = '0;
      top_d = '0;
      ovf_d = 1'b0;
      unf_d = 1'b0;
    end else begin
      unique case ({stack_w_en, stack_r_en})
        2'b10: begin
          if (is_full) begin
            ovf_d = 1'b1;
          end else begin
            mem_we = 1'b1;
            sp_d   = sp_q + DW'(1);
            top_d  = push_data;
          end
        end
        2'b01: begin
          if (is_empty) begin
            unf_d = 1'b1;
          end else if (sp_q == DW'(1)) begin
            sp_d  = '0;
            top_d = '0;
          end else begin
            sp_d  = sp_q - DW'(1);
            top_d = mem[idx_below];
          end
        end
        2'b11: begin
          // Replace top; from empty this degenerates to a push plus underflow.
          mem_we = 1'b1;
          top_d  = push_data;
          if (is_empty) begin
            unf_d     = 1'b1;
            mem_waddr = '0;
            sp_d      = DW'(1);
          end else begin
            mem_waddr = idx_top;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      sp_q  <= '0;
      top_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      sp_q  <= sp_d;
      top_q <= top_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  // NOTE: the storage array is deliberately not reset; sp gates which entries
  // are valid, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (!rst && mem_we) begin
      mem[mem_waddr] <= push_data;
    end
  end

  assign pop_data  = top_q;
  assign depth     = sp_q;
  assign empty     = is_empty;
  assign full      = is_full;
  assign overflow  = ovf_q;
  assign underflow = unf_q;

endmodule

// File: tb/tb_data_stack.sv
// Self-checking bench for data_stack: queue-based reference model compared
// every cycle, plus directed literal expectations from the test plan.
module tb_data_stack;

  localparam int WIDTH = 8;
  localparam int DEPTH = 8;
  localparam int DW    = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             clear = 1'b0;
  logic             stack_w_en = 1'b0;
  logic             stack_r_en = 1'b0;
  logic [WIDTH-1:0] push_data = '0;
  logic [WIDTH-1:0] pop_data;
  logic [DW-1:0]    depth;
  logic             empty;
  logic             full;
  logic             overflow;
  logic             underflow;

  int n_cmp = 0;
  int n_err = 0;

  logic [WIDTH-1:0] m_q[$];
  bit               m_ovf = 0;
  bit               m_unf = 0;

  data_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .clear      (clear),
    .stack_w_en (stack_w_en),
    .stack_r_en (stack_r_en),
    .push_data  (push_data),
    .pop_data   (pop_data),
    .depth      (depth),
    .empty      (empty),
    .full       (full),
    .overflow   (overflow),
    .underflow  (underflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [WIDTH-1:0] m_top();
    return (m_q.size() == 0) ? '0 : m_q[$];
  endfunction

  // Reference behaviour: a LIFO queue with bounded size and sticky flags.
  task automatic model_step(input bit r, input bit c, input bit w, input bit p, input logic [WIDTH-1:0] d);
    if (r || c) begin
      m_q.delete();
      m_ovf = 0;
      m_unf = 0;
    end else if (w && !p) begin
      if (m_q.size() == DEPTH) m_ovf = 1;
      else m_q.push_back(d);
    end else if (!w && p) begin
      if (m_q.size() == 0) m_unf = 1;
      else void'(m_q.pop_back());
    end else if (w && p) begin
      if (m_q.size() == 0) begin
        m_unf = 1;
        m_q.push_back(d);
      end else begin
        m_q[m_q.size()-1] = d;
      end
    end
  endtask

  // One clock of stimulus; a pop checks the value the consumer samples.
  task automatic op(input bit r, input bit c, input bit w, input bit p, input logic [WIDTH-1:0] d);
    rst = r; clear = c; stack_w_en = w; stack_r_en = p; push_data = d;
    if (p && !r && !c) begin
      #1;
      check("pop_sample_model", pop_data, m_top());
    end
    @(posedge clk);
    #1;
    model_step(r, c, w, p, d);
    rst = 0; clear = 0; stack_w_en = 0; stack_r_en = 0; push_data = '0;
  endtask

  task automatic push(input logic [WIDTH-1:0] d); op(0, 0, 1, 0, d); endtask

  task automatic pop_expect(input logic [WIDTH-1:0] exp);
    #1;
    check("pop_sample_lit", pop_data, exp);
    op(0, 0, 0, 1, '0);
  endtask

  task automatic expect_state(input string tag, input logic [WIDTH-1:0] e_pop,
                              input int e_depth, input bit e_ovf, input bit e_unf);
    check({tag, ".pop_data"}, pop_data, e_pop);
    check({tag, ".depth"}, depth, e_depth);
    check({tag, ".overflow"}, overflow, e_ovf);
    check({tag, ".underflow"}, underflow, e_unf);
  endtask

  always @(negedge clk) begin
    check("cyc.pop_data", pop_data, m_top());
    check("cyc.depth", depth, m_q.size());
    check("cyc.empty", empty, m_q.size() == 0);
    check("cyc.full", full, m_q.size() == DEPTH);
    check("cyc.overflow", overflow, m_ovf);
    check("cyc.underflow", underflow, m_unf);
  end

  initial begin
    logic [WIDTH-1:0] v;

    op(1, 0, 0, 0, '0);
    op(1, 0, 0, 0, '0);
    op(0, 0, 0, 0, '0);
    expect_state("reset", 8'h00, 0, 0, 0);
    check("reset.empty", empty, 1);
    check("reset.full", full, 0);

    for (int i = 1; i <= DEPTH; i++) begin
      v = {i[3:0], i[3:0]};
      push(v);
    end
    expect_state("fill", 8'h88, 8, 0, 0);
    check("fill.full", full, 1);

    push(8'h99);
    expect_state("overflow", 8'h88, 8, 1, 0);

    for (int i = DEPTH; i >= 1; i--) begin
      v = {i[3:0], i[3:0]};
      pop_expect(v);
    end
    expect_state("drain", 8'h00, 0, 1, 0);
    check("drain.empty", empty, 1);

    op(0, 1, 0, 0, '0);
    op(0, 0, 0, 1, '0);
    expect_state("underflow_pop", 8'h00, 0, 0, 1);
    op(0, 0, 1, 1, 8'h5A);
    expect_state("underflow_pushpop", 8'h5A, 1, 0, 1);

    op(0, 1, 0, 0, '0);
    push(8'h01);
    push(8'h02);
    #1 check("replace.pre", pop_data, 8'h02);
    op(0, 0, 1, 1, 8'h7F);
    expect_state("replace", 8'h7F, 2, 0, 0);
    pop_expect(8'h7F);
    expect_state("replace_pop", 8'h01, 1, 0, 0);

    op(0, 1, 0, 0, '0);
    for (int i = 0; i < DEPTH; i++) push(8'hC0 + 8'(i));
    op(0, 0, 1, 1, 8'hAA);
    expect_state("replace_full", 8'hAA, 8, 0, 0);
    pop_expect(8'hAA);
    expect_state("replace_full_pop", 8'hC6, 7, 0, 0);

    for (int k = 0; k < 2; k++) begin
      op(0, 1, 0, 0, '0);
      op(0, 0, 0, 1, '0);
      for (int i = 0; i < DEPTH; i++) push(8'h30 + 8'(i));
      push(8'hEE);
      for (int i = 0; i < DEPTH - 3; i++) op(0, 0, 0, 1, '0);
      expect_state("pre_flush", 8'h32, 3, 1, 1);
      if (k == 0) op(0, 1, 1, 0, 8'hEE);
      else        op(1, 0, 1, 0, 8'hEE);
      expect_state(k == 0 ? "clear_flush" : "rst_flush", 8'h00, 0, 0, 0);
      check("flush.empty", empty, 1);
    end

    push(8'h42);
    pop_expect(8'h42);
    expect_state("final", 8'h00, 0, 0, 0);

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
